// File: rtl/wb_regfile.sv
// MEM/WB consumer: selects the writeback value, commits it into the register file, serves two async read ports.
// Optional macro WB_BYPASS_EN adds write-through bypass from the pending writeback to the read ports.
module wb_regfile #(
  parameter int NREGS           = 16,
  parameter int DW              = 32,
  parameter int ZERO_REG_EN_IDX = 0,
  localparam int AW             = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemToReg_in,
  input  logic          RegWrite_in,
  input  logic [DW-1:0] mem_in,
  input  logic [DW-1:0] alu_in,
  input  logic [AW-1:0] RR3_in,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [DW-1:0] wb_data,
  output logic          wb_valid,
  output logic [31:0]   wb_count
);

  logic [DW-1:0] r_regs [NREGS];
  logic [31:0]   r_count;
  logic          w_rr3InRange;

  assign wb_data      = MemToReg_in ? mem_in : alu_in;
  assign w_rr3InRange = int'(RR3_in) < NREGS;
  assign wb_valid     = RegWrite_in && (int'(RR3_in) != ZERO_REG_EN_IDX);
  assign wb_count     = r_count;

  // The zero register is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (wb_valid && w_rr3InRange) begin
      r_regs[RR3_in] <= wb_data;
      r_count        <= r_count + 32'd1;
    end
  end

  always_comb begin
    rd1 = '0;
    if (int'(ra1) < NREGS && int'(ra1) != ZERO_REG_EN_IDX) rd1 = r_regs[ra1];
`ifdef WB_BYPASS_EN
    if (wb_valid && ra1 == RR3_in) rd1 = wb_data;
`endif
  end

  always_comb begin
    rd2 = '0;
    if (int'(ra2) < NREGS && int'(ra2) != ZERO_REG_EN_IDX) rd2 = r_regs[ra2];
`ifdef WB_BYPASS_EN
    if (wb_valid && ra2 == RR3_in) rd2 = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: scoreboard of expected register/counter state after each commit.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic [31:0] mem_in;
  logic [31:0] alu_in;
  logic [3:0]  RR3_in;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wb_count;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] count;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] modelRegs [16];
  logic [31:0] modelCount;
  int          checks;
  int          failures;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .MemToReg_in(MemToReg_in),
    .RegWrite_in(RegWrite_in),
    .mem_in     (mem_in),
    .alu_in     (alu_in),
    .RR3_in     (RR3_in),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid),
    .wb_count   (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelClear();
    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
    modelCount = '0;
    sbq.delete();
  endtask

  task automatic driveIdle();
    RegWrite_in = 1'b0;
    MemToReg_in = 1'b0;
    mem_in      = '0;
    alu_in      = '0;
    RR3_in      = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    driveIdle();
    rst = 1'b1;
    #2;
    modelClear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Launch one MEM/WB transaction on the negedge and push the expected post-commit state.
  task automatic launch(input logic we, input logic mtr, input logic [31:0] mem,
                        input logic [31:0] alu, input logic [3:0] rr3);
    logic [31:0] sel;
    logic        valid;
    exp_t        e;
    @(negedge clk);
    #1;
    RegWrite_in = we;
    MemToReg_in = mtr;
    mem_in      = mem;
    alu_in      = alu;
    RR3_in      = rr3;
    sel   = mtr ? mem : alu;
    valid = we && (rr3 != 4'd0);
    if (valid) begin
      modelRegs[rr3] = sel;
      modelCount     = modelCount + 32'd1;
    end
    e.addr  = rr3;
    e.data  = modelRegs[rr3];
    e.count = modelCount;
    sbq.push_back(e);
    #1;
    checks++;
    if (wb_data !== sel) begin
      failures++;
      $display("[TB] FAIL wb_data: got %h expected %h", wb_data, sel);
    end
    checks++;
    if (wb_valid !== valid) begin
      failures++;
      $display("[TB] FAIL wb_valid: got %b expected %b", wb_valid, valid);
    end
  endtask

  task automatic commitCheck(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty at commit", name);
    end else begin
      e   = sbq.pop_front();
      ra1 = e.addr;
      #1;
      if (rd1 !== e.data) begin
        failures++;
        $display("[TB] FAIL %s rd1[r%0d]: got %h expected %h", name, e.addr, rd1, e.data);
      end
      checks++;
      if (wb_count !== e.count) begin
        failures++;
        $display("[TB] FAIL %s wb_count: got %h expected %h", name, wb_count, e.count);
      end
    end
  endtask

  task automatic checkAllRegs(input string name);
    for (int i = 0; i < 16; i++) begin
      ra2 = 4'(i);
      #1;
      checks++;
      if (rd2 !== modelRegs[i]) begin
        failures++;
        $display("[TB] FAIL %s r%0d: got %h expected %h", name, i, rd2, modelRegs[i]);
      end
    end
  endtask

  task automatic test_reset();
    ra1 = 4'd5;
    #1;
    checks++;
    if (rd1 !== 32'h0 || wb_count !== 32'h0 || wb_valid !== 1'b0 || wb_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_state: rd1=%h cnt=%h valid=%b data=%h expected all 0",
               rd1, wb_count, wb_valid, wb_data);
    end
    launch(1'b1, 1'b0, 32'h0, 32'h1234, 4'd5);
    commitCheck("load_r5");
    // A pending write to r6 is launched, then reset is asserted before its posedge.
    launch(1'b1, 1'b0, 32'h0, 32'h5555, 4'd6);
    #2;
    rst = 1'b1;
    ra1 = 4'd5;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_async_rd1: got %h expected %h", rd1, 32'h0);
    end
    checks++;
    if (wb_count !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_async_count: got %h expected %h", wb_count, 32'h0);
    end
    modelClear();
    @(posedge clk);
    #1;
    ra1 = 4'd6;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_pending_dropped: got %h expected %h", rd1, 32'h0);
    end
    @(negedge clk);
    driveIdle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAllRegs("after_reset");
  endtask

  task automatic test_mux();
    launch(1'b1, 1'b1, 32'hDEADBEEF, 32'h11, 4'd3);
    commitCheck("mux_mem");
    launch(1'b1, 1'b0, 32'hDEADBEEF, 32'h11, 4'd3);
    commitCheck("mux_alu");
  endtask

  task automatic test_write_disable();
    launch(1'b0, 1'b0, 32'h0, 32'hFF, 4'd4);
    commitCheck("write_disabled");
    launch(1'b1, 1'b0, 32'h0, 32'hFF, 4'd0);
    ra1 = 4'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL zero_reg_pre_edge: got %h expected %h", rd1, 32'h0);
    end
    commitCheck("zero_reg");
  endtask

  task automatic test_bypass();
    logic [31:0] preExp;
    launch(1'b1, 1'b0, 32'h0, 32'hA, 4'd7);
    commitCheck("bypass_setup");
    launch(1'b1, 1'b0, 32'h0, 32'hB, 4'd7);
    ra1 = 4'd7;
    ra2 = 4'd7;
    #1;
`ifdef WB_BYPASS_EN
    preExp = 32'hB;
`else
    preExp = 32'hA;
`endif
    checks++;
    if (rd1 !== preExp) begin
      failures++;
      $display("[TB] FAIL bypass_rd1_pre: got %h expected %h", rd1, preExp);
    end
    checks++;
    if (rd2 !== preExp) begin
      failures++;
      $display("[TB] FAIL bypass_rd2_pre: got %h expected %h", rd2, preExp);
    end
    commitCheck("bypass_post");
    checks++;
    if (rd2 !== 32'hB) begin
      failures++;
      $display("[TB] FAIL bypass_rd2_post: got %h expected %h", rd2, 32'hB);
    end
  endtask

  task automatic test_wrap();
    doReset();
    @(negedge clk);
    force dut.r_count = 32'hFFFFFFFF;
    #1;
    release dut.r_count;
    modelCount = 32'hFFFFFFFF;
    #1;
    checks++;
    if (wb_count !== 32'hFFFFFFFF) begin
      failures++;
      $display("[TB] FAIL wrap_preload: got %h expected %h", wb_count, 32'hFFFFFFFF);
    end
    launch(1'b1, 1'b0, 32'h0, 32'hCAFE, 4'd1);
    commitCheck("wrap");
  endtask

  task automatic test_back_to_back();
    doReset();
    launch(1'b1, 1'b0, 32'h0, 32'h1, 4'd2);
    commitCheck("b2b_r2_1");
    launch(1'b1, 1'b1, 32'h2, 32'h0, 4'd2);
    commitCheck("b2b_r2_2");
    launch(1'b1, 1'b0, 32'h0, 32'h3, 4'd9);
    commitCheck("b2b_r9_3");
    @(negedge clk);
    driveIdle();
    #1;
    checks++;
    if (wb_count !== 32'd3) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d expected %0d", wb_count, 3);
    end
    checkAllRegs("b2b_final");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ra1      = '0;
    ra2      = '0;
    driveIdle();
    modelClear();
    #12;
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_mux();
    test_write_disable();
    test_bypass();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline segment.
- Takes the registered writeback controls and data from the MEM/WB segment. Selects the writeback value (memory or ALU result) and commits it into a 16 x 32-bit register file.
- Serves two asynchronous read ports to the decode stage.
- Exposes the selected writeback value for EX-stage forwarding, plus a retired-write counter for debug.

Parameters:
- NREGS, 16, number of architectural registers; address width is clog2(NREGS) = 4.
- DW, 32, data width of registers and writeback paths.
- ZERO_REG_EN_IDX, 0, index of the hardwired-zero register.

Ports:
- clk  in  1  system clock; MEM/WB segment launches on negedge, this block commits on posedge.
- rst  in  1  reset, asynchronous, active-high.
- MemToReg_in  in  1  1 = write mem_in, 0 = write alu_in.
- RegWrite_in  in  1  write enable from the MEM/WB segment.
- mem_in  in  DW  data memory result from the MEM/WB segment.
- alu_in  in  DW  ALU result from the MEM/WB segment.
- RR3_in  in  4  destination register index from the MEM/WB segment.
- ra1  in  4  read address, port 1.
- ra2  in  4  read address, port 2.
- rd1  out  DW  read data, port 1.
- rd2  out  DW  read data, port 2.
- wb_data  out  DW  selected writeback value, for forwarding.
- wb_valid  out  1  RegWrite_in AND (RR3_in != ZERO_REG_EN_IDX).
- wb_count  out  32  number of committed register writes.

Behaviour:
- wb_data is combinational: MemToReg_in ? mem_in : alu_in. It is valid regardless of RegWrite_in.
- Commit occurs at posedge clk when wb_valid = 1: regs[RR3_in] <= wb_data.
  - Latency: data launched by the segment at negedge N is architecturally visible on rd1/rd2 after posedge N+1/2, i.e. half a cycle later.
- Writes to register ZERO_REG_EN_IDX are dropped. Reads of it always return 0. A write to it does not increment wb_count.
- Reads are combinational: rd1 = regs[ra1], rd2 = regs[ra2]. Any address not in 0..NREGS-1 reads 0. With NREGS = 16 no such address exists.
- wb_count increments by 1 at each posedge with wb_valid = 1. It wraps 0xFFFFFFFF -> 0.
- Same-address reads on both ports are legal and return identical data.
- Reset (async, asserted at any time, including mid-cycle between the negedge launch and the posedge commit):
  - all regs = 0; wb_count = 0.
  - The pending write is discarded.
  - rd1/rd2 read 0 immediately.
  - wb_data and wb_valid follow inputs combinationally. The MEM/WB segment also clears under the same rst, so they settle to 0/0.
- Release of rst: the first commit is possible at the first posedge after deassertion.
- Inputs are sampled only at posedge. Glitches between edges do not modify state.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: write-through bypass. If wb_valid = 1 and raN == RR3_in, then rdN = wb_data in the same cycle, before the posedge commit. This removes the one-cycle WB->ID hazard. Bypass never applies to register ZERO_REG_EN_IDX.
- Not defined: rdN always reflects stored register contents. The same-cycle read returns the old value; the new value appears after the posedge commit.

Test Plan:
- Reset: load r5 = 0x1234, assert rst between edges -> rd1 (ra1 = 5) reads 0 immediately, wb_count = 0. After release, regs stay 0 until written.
- Mux/commit:
  - RegWrite = 1, MemToReg = 1, mem_in = 0xDEADBEEF, alu_in = 0x11, RR3 = 3 -> after posedge, rd1 (ra1 = 3) = 0xDEADBEEF, wb_count = 1.
  - Repeat with MemToReg = 0 -> rd1 = 0x11, wb_count = 2.
- Write disabled and zero register:
  - RegWrite = 0, RR3 = 4, alu_in = 0xFF -> r4 unchanged (0), wb_count unchanged, wb_valid = 0.
  - RegWrite = 1, RR3 = 0, alu_in = 0xFF -> rd1 (ra1 = 0) = 0, wb_count unchanged, wb_valid = 0.
- Bypass: r7 = 0xA, then drive RegWrite = 1, RR3 = 7, alu_in = 0xB, ra1 = ra2 = 7 before the posedge.
  - With WB_BYPASS_EN: rd1 = rd2 = 0xB before the edge.
  - Without WB_BYPASS_EN: 0xA before the edge, 0xB after.
- Counter wrap: force wb_count to 0xFFFFFFFF, perform one valid write to r1 -> wb_count = 0, r1 updated.
- Back-to-back: write r2 = 1, r2 = 2, r9 = 3 on consecutive cycles -> final r2 = 2, r9 = 3, wb_count = 3, other regs 0.
